// File: rtl/ps2_bus_ctrl.sv
// Bus-side register/buffer controller for the PS/2 engines: RX FIFO, TX holding byte,
// sticky status flags and IRQ. Optional IRQ_EN register and interrupt under `PS2_BUS_CTRL_IRQ_EN.
module ps2_bus_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       addr,
    input  logic       rd_strobe,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    output logic [7:0] read_reg,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       irq_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          rd_prev, wr_prev;
    logic          rx_ovr, rx_err_f, tx_ovr, irq_en;

    logic rd_ev, wr_ev, full, empty, pop, push, ovf, flush, stat_clr, data_wr, tx_done;
    logic [7:0] status, head;

    always_comb begin
        rd_ev    = rd_strobe & ~rd_prev;
        wr_ev    = wr_strobe & ~wr_prev;
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        pop      = rd_ev & ~addr & ~empty;
        flush    = wr_ev & addr & wr_data[7];
        // A same-cycle pop makes room, so a push into a full FIFO is not an overflow.
        push     = rx_valid & ~flush & (~full | pop);
        ovf      = rx_valid & ~flush & full & ~pop;
        stat_clr = rd_ev & addr;
        data_wr  = wr_ev & ~addr;
        tx_done  = tx_valid & tx_ready;
        head     = empty ? 8'h00 : mem[rptr];
        status   = {1'b0, irq_en, tx_ovr, tx_valid, rx_err_f, rx_ovr, full, ~empty};
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prev  <= 1'b0;
            wr_prev  <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rx_ovr   <= 1'b0;
            rx_err_f <= 1'b0;
            tx_ovr   <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            read_reg <= 8'h00;
        end else begin
            rd_prev  <= rd_strobe;
            wr_prev  <= wr_strobe;
            read_reg <= addr ? status : head;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            // Sticky flags: a set in the same cycle as a status-read clear wins.
            if (ovf)           rx_ovr <= 1'b1;
            else if (stat_clr) rx_ovr <= 1'b0;
            if (rx_err)        rx_err_f <= 1'b1;
            else if (stat_clr) rx_err_f <= 1'b0;
            if (data_wr && tx_valid) tx_ovr <= 1'b1;
            else if (stat_clr)       tx_ovr <= 1'b0;
            // Write acceptance looks at pre-edge tx_valid, so a write racing the handshake drops.
            if (data_wr && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= wr_data;
            end else if (tx_done) begin
                tx_valid <= 1'b0;
            end
        end
    end

`ifdef PS2_BUS_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq_n  <= 1'b1;
        end else begin
            if (wr_ev && addr) irq_en <= wr_data[0];
            irq_n <= ~(irq_en & (~empty | rx_ovr | rx_err_f));
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_n  = 1'b1;
`endif

endmodule
